// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score keeper: FSM state encoding,
// serve-side ball codes, parameter defaults and a BCD-to-binary helper.
package score_keeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam logic [1:0] BALL_NONE  = 2'b00;
    localparam logic [1:0] BALL_LEFT  = 2'b01;
    localparam logic [1:0] BALL_RIGHT = 2'b10;

    localparam int WIN_SCORE_DEF    = 11;
    localparam int SERVE_FRAMES_DEF = 120;

    // Two BCD digits to a binary value 0..99, used for the win comparison.
    function automatic logic [6:0] bcd2_to_bin(input logic [3:0] tens,
                                               input logic [3:0] ones);
        logic [6:0] tens_w;
        logic [6:0] ones_w;
        tens_w = {3'b000, tens};
        ones_w = {3'b000, ones};
        return (tens_w * 7'd10) + ones_w;
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Game-control bus: event pulses in, score digits and overlay controls out.
interface score_keeper_if;
    logic       frame_tick;
    logic       start;
    logic       point_l;
    logic       point_r;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic [1:0] ball;
    logic       ball_en;
    logic       game_over;

    // Driver of events / consumer of display state.
    modport master (
        output frame_tick, start, point_l, point_r,
        input  dig0, dig1, dig2, dig3, ball, ball_en, game_over
    );

    // The score keeper itself.
    modport slave (
        input  frame_tick, start, point_l, point_r,
        output dig0, dig1, dig2, dig3, ball, ball_en, game_over
    );
endinterface

// File: rtl/score_keeper_bcd2_counter.sv
// Two-digit BCD score counter with clear, increment and saturation at 99.
// Also exposes the incremented value so the caller can test a win before
// committing the point.
module bcd2_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] ones_inc,
    output logic [3:0] tens_inc
);
    logic [3:0] ones_q;
    logic [3:0] ones_d;
    logic [3:0] tens_q;
    logic [3:0] tens_d;
    logic [3:0] ones_p1_s;
    logic [3:0] tens_p1_s;

    // Saturating BCD +1 of the current value; a ones digit >= 9 carries so no nibble above 9 is produced.
    always_comb begin
        ones_p1_s = ones_q;
        tens_p1_s = tens_q;
        if ((tens_q >= 4'd9) && (ones_q >= 4'd9)) begin
            ones_p1_s = 4'd9;
            tens_p1_s = 4'd9;
        end else if (ones_q >= 4'd9) begin
            ones_p1_s = 4'd0;
            tens_p1_s = tens_q + 4'd1;
        end else begin
            ones_p1_s = ones_q + 4'd1;
            tens_p1_s = tens_q;
        end
    end

    // Next count: clear wins over increment, otherwise hold.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (clr) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (inc) begin
            ones_d = ones_p1_s;
            tens_d = tens_p1_s;
        end else begin
            ones_d = ones_q;
            tens_d = tens_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign ones     = ones_q;
    assign tens     = tens_q;
    assign ones_inc = ones_p1_s;
    assign tens_inc = tens_p1_s;

endmodule

// File: rtl/score_keeper.sv
// Pong-style score keeper: game FSM, serve-pause timer and two BCD score
// counters. All display outputs are registered.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    score_keeper_if.slave  sk
);
    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
    localparam logic [6:0] WIN_BIN    = 7'(WIN_SCORE);

    state_e     state_q;
    state_e     state_d;
    logic [7:0] timer_q;
    logic [7:0] timer_d;
    logic [1:0] ball_q;
    logic [1:0] ball_d;
    logic       ball_en_q;
    logic       ball_en_d;
    logic       game_over_q;
    logic       game_over_d;

    logic       clr_s;
    logic       inc_l_s;
    logic       inc_r_s;
    logic       win_s;
    logic [3:0] l_ones_s;
    logic [3:0] l_tens_s;
    logic [3:0] r_ones_s;
    logic [3:0] r_tens_s;
    logic [3:0] l_ones_inc_s;
    logic [3:0] l_tens_inc_s;
    logic [3:0] r_ones_inc_s;
    logic [3:0] r_tens_inc_s;

    bcd2_counter u_left (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clr_s),
        .inc      (inc_l_s),
        .ones     (l_ones_s),
        .tens     (l_tens_s),
        .ones_inc (l_ones_inc_s),
        .tens_inc (l_tens_inc_s)
    );

    bcd2_counter u_right (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clr_s),
        .inc      (inc_r_s),
        .ones     (r_ones_s),
        .tens     (r_tens_s),
        .ones_inc (r_ones_inc_s),
        .tens_inc (r_tens_inc_s)
    );

    // Win test on the post-point score of whichever side(s) scored this cycle.
    always_comb begin
        win_s = 1'b0;
        if (sk.point_l && (bcd2_to_bin(l_tens_inc_s, l_ones_inc_s) >= WIN_BIN)) begin
            win_s = 1'b1;
        end else if (sk.point_r && (bcd2_to_bin(r_tens_inc_s, r_ones_inc_s) >= WIN_BIN)) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Game FSM next state, serve timer, serve side and counter controls.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ball_d  = ball_q;
        clr_s   = 1'b0;
        inc_l_s = 1'b0;
        inc_r_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (sk.start) begin
                    clr_s   = 1'b1;
                    ball_d  = BALL_LEFT;
                    timer_d = SERVE_LOAD;
                    state_d = ST_SERVE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SERVE: begin
                if (sk.frame_tick) begin
                    if (timer_q <= 8'd1) begin
                        timer_d = 8'd0;
                        state_d = ST_PLAY;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end else begin
                    timer_d = timer_q;
                end
            end
            ST_PLAY: begin
                if (sk.point_l || sk.point_r) begin
                    inc_l_s = sk.point_l;
                    inc_r_s = sk.point_r;
                    if (win_s) begin
                        ball_d  = BALL_NONE;
                        timer_d = 8'd0;
                        state_d = ST_OVER;
                    end else begin
                        timer_d = SERVE_LOAD;
                        state_d = ST_SERVE;
                        if (sk.point_l && !sk.point_r) begin
                            ball_d = BALL_RIGHT;
                        end else if (sk.point_r && !sk.point_l) begin
                            ball_d = BALL_LEFT;
                        end else begin
                            ball_d = ball_q;
                        end
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ball_d  = BALL_NONE;
                timer_d = 8'd0;
            end
        endcase
        ball_en_d   = (state_d == ST_PLAY);
        game_over_d = (state_d == ST_OVER);
    end

    // State, timer and registered control outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= 8'd0;
            ball_q      <= BALL_NONE;
            ball_en_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ball_q      <= ball_d;
            ball_en_q   <= ball_en_d;
            game_over_q <= game_over_d;
        end
    end

    assign sk.dig0      = l_ones_s;
    assign sk.dig1      = l_tens_s;
    assign sk.dig2      = r_ones_s;
    assign sk.dig3      = r_tens_s;
    assign sk.ball      = ball_q;
    assign sk.ball_en   = ball_en_q;
    assign sk.game_over = game_over_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: two instances (default 11/120 and 99/2) share the
// same event stream; an integer-score reference model predicts every output.
module tb_score_keeper;

    logic clk;
    logic reset_n;

    score_keeper_if if0 ();
    score_keeper_if if1 ();

    score_keeper u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .sk      (if0.slave)
    );

    score_keeper #(.WIN_SCORE(99), .SERVE_FRAMES(2)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .sk      (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: dig3 dig2 dig1 dig0 ball ball_en game_over
    logic [19:0] obs0;
    logic [19:0] obs1;
    assign obs0 = {if0.dig3, if0.dig2, if0.dig1, if0.dig0, if0.ball, if0.ball_en, if0.game_over};
    assign obs1 = {if1.dig3, if1.dig2, if1.dig1, if1.dig0, if1.ball, if1.ball_en, if1.game_over};

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0 idle, 1 serve, 2 play, 3 over; scores as integers.
    int m_win  [2] = '{11, 99};
    int m_frm  [2] = '{120, 2};
    int m_mode [2];
    int m_sl   [2];
    int m_sr   [2];
    int m_tmr  [2];
    int m_ball [2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_sl[k] = 0; m_sr[k] = 0; m_tmr[k] = 0; m_ball[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit st, input bit tk, input bit pl, input bit pr);
        case (m_mode[k])
            0, 3: if (st) begin
                m_sl[k] = 0; m_sr[k] = 0; m_ball[k] = 1; m_tmr[k] = m_frm[k]; m_mode[k] = 1;
            end
            1: if (tk) begin
                if (m_tmr[k] <= 1) begin m_tmr[k] = 0; m_mode[k] = 2; end
                else m_tmr[k] = m_tmr[k] - 1;
            end
            2: if (pl || pr) begin
                if (pl && m_sl[k] < 99) m_sl[k] = m_sl[k] + 1;
                if (pr && m_sr[k] < 99) m_sr[k] = m_sr[k] + 1;
                if (m_sl[k] >= m_win[k] || m_sr[k] >= m_win[k]) begin
                    m_mode[k] = 3; m_ball[k] = 0;
                end else begin
                    m_mode[k] = 1; m_tmr[k] = m_frm[k];
                    if (pl && !pr) m_ball[k] = 2;
                    else if (pr && !pl) m_ball[k] = 1;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [19:0] exp_pack(input int k);
        logic [3:0] d3, d2, d1, d0;
        logic [1:0] b;
        d3 = 4'(m_sr[k] / 10); d2 = 4'(m_sr[k] % 10);
        d1 = 4'(m_sl[k] / 10); d0 = 4'(m_sl[k] % 10);
        b  = 2'(m_ball[k]);
        return {d3, d2, d1, d0, b, (m_mode[k] == 2), (m_mode[k] == 3)};
    endfunction

    task automatic set_inputs(input bit st, input bit tk, input bit pl, input bit pr);
        if0.start = st; if0.frame_tick = tk; if0.point_l = pl; if0.point_r = pr;
        if1.start = st; if1.frame_tick = tk; if1.point_l = pl; if1.point_r = pr;
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic drive(input bit st, input bit tk, input bit pl, input bit pr);
        set_inputs(st, tk, pl, pr);
        @(posedge clk);
        model_step(0, st, tk, pl, pr);
        model_step(1, st, tk, pl, pr);
        @(negedge clk);
        check_eq("model0", 32'(obs0), 32'(exp_pack(0)));
        check_eq("model1", 32'(obs1), 32'(exp_pack(1)));
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset mid-cycle with every event input active.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        set_inputs(1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        check_eq("rst_async0", 32'(obs0), 32'h0);
        check_eq("rst_async1", 32'(obs1), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_dom0", 32'(obs0), 32'h0);
        check_eq("rst_dom1", 32'(obs1), 32'h0);
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("reset0", 32'(obs0), 32'h0);
        check_eq("reset1", 32'(obs1), 32'h0);
        reset_n = 1'b1;

        // Point before any start is ignored; start opens a serve from the left.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("idle_ignore", 32'(obs0), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("start", 32'(obs0), 32'h00004);

        repeat (119) drive(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("serve_hold", 32'(obs0[1]), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("serve_done", 32'(obs0[1]), 32'h1);

        // Ten left points: carry 9 -> 10.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            repeat (120) drive(1'b0, 1'b1, 1'b0, 1'b0);
        end
        check_eq("carry10", 32'(obs0[11:4]), 32'h10);
        check_eq("not_over", 32'(obs0[0]), 32'h0);

        // Eleventh point wins; later points ignored.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("win_dig", 32'(obs0[11:4]), 32'h11);
        check_eq("win_ctl", 32'(obs0[3:0]), 32'h1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("over_hold", 32'(obs0), 32'h00111);

        // Restart; point during serve ignored; reset in play.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("serve_ignore", 32'(obs0), 32'h00004);
        repeat (120) drive(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("play_again", 32'(obs0[1]), 32'h1);
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("need_start", 32'(obs0), 32'h0);

        // Randomized play against the model.
        for (int c = 0; c < 12000; c++) begin
            if ($urandom_range(0, 2999) == 0) begin
                do_reset();
            end else begin
                drive(($urandom_range(0, 63) == 0),
                      ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 5) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
